// File: rtl/seq_scan_controller_pkg.sv
// Shared types for the serial scan controller.
// State encoding and the pattern the attached detector looks for.
package seq_scan_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [4:0] SCAN_PATTERN = 5'b10110;

endpackage

// File: rtl/seq_scan_controller.sv
// Shifts a parallel word MSB-first into a clock-enabled pattern
// detector and counts the detector's qualified hit pulses.
module seq_scan_controller
  import seq_scan_controller_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             det_clear,
  output logic             det_en,
  output logic             det_in,
  input  logic             det_hit
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    pend_d  = (state_q == ST_SHIFT);

    // pend marks the cycle right after a consumed bit
    if (pend_q && det_hit) begin
      hit_d = hit_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = data_in;
          cnt_d   = '0;
          hit_d   = '0;
          pend_d  = 1'b0;
          state_d = cont ? ST_SHIFT : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + BIT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      pend_q  <= pend_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign det_clear = (state_q == ST_CLEAR);
  assign det_en    = (state_q == ST_SHIFT);
  assign det_in    = det_en & shreg_q[WIDTH-1];
  assign hit_count = hit_q;

endmodule

// File: tb/tb_seq_scan_controller.sv
// Bench for seq_scan_controller with a behavioural 10110 detector
// and a bit-stream reference model of the expected match count.
module tb_seq_scan_controller;
  import seq_scan_controller_pkg::*;

  localparam int W  = 16;
  localparam int CW = $clog2(W) + 1;

  logic          clock;
  logic          reset;
  logic          start;
  logic          cont;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] hit_count;
  logic          det_clear;
  logic          det_en;
  logic          det_in;
  logic          det_hit;

  int checks;
  int errors;

  seq_scan_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cont      (cont),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count),
    .det_clear (det_clear),
    .det_en    (det_en),
    .det_in    (det_in),
    .det_hit   (det_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Detector: window of the last five consumed bits since clear
  logic [4:0] dh_q;
  logic [2:0] dn_q;
  logic       dhit_q;
  logic       force_hit;

  always @(posedge clock) begin
    if (reset) begin
      dh_q   <= '0;
      dn_q   <= '0;
      dhit_q <= 1'b0;
    end else if (det_clear) begin
      dn_q   <= '0;
      dhit_q <= 1'b0;
    end else if (det_en) begin
      dh_q   <= {dh_q[3:0], det_in};
      dn_q   <= (dn_q < 3'd5) ? dn_q + 3'd1 : 3'd5;
      dhit_q <= (dn_q >= 3'd4) &&
                ({dh_q[3:0], det_in} == SCAN_PATTERN);
    end
  end

  assign det_hit = dhit_q | force_hit;

  bit ref_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_scan(input logic [W-1:0] d,
                          input logic c,
                          output int hits);
    logic [4:0] w;
    hits = 0;
    if (!c) ref_q.delete();
    for (int i = W - 1; i >= 0; i--) begin
      ref_q.push_back(d[i]);
      if (ref_q.size() > 5) void'(ref_q.pop_front());
      if (ref_q.size() == 5) begin
        w = {ref_q[0], ref_q[1], ref_q[2], ref_q[3], ref_q[4]};
        if (w == SCAN_PATTERN) hits++;
      end
    end
  endtask

  task automatic scan(input logic [W-1:0] d,
                      input logic c,
                      input bit stale,
                      input bit glitch,
                      input string tag);
    int exp_hits;
    int exp_done;
    int done_at;
    int done_n;
    int clr_at;
    int clr_n;
    int nbits;
    logic [W-1:0] seen;
    ref_scan(d, c, exp_hits);
    exp_done = c ? W + 2 : W + 3;
    done_at = 0; done_n = 0;
    clr_at = 0; clr_n = 0;
    nbits = 0; seen = '0;
    start = 1'b1; data_in = d; cont = c;
    @(posedge clock); #1;
    data_in = W'($urandom);
    cont = 1'($urandom);
    for (int cyc = 1; cyc <= W + 5; cyc++) begin
      force_hit = stale &&
        (cyc == 1 || cyc == W + 3 || cyc == W + 4);
      if (glitch && cyc == 6) begin
        start = 1'b1; data_in = ~d; cont = ~c;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) begin
        chk({tag, "_busy1"}, busy, 1'b1);
        chk({tag, "_hit0"}, hit_count, '0);
      end
      if (det_clear) begin clr_n++; clr_at = cyc; end
      if (det_en) begin
        seen = {seen[W-2:0], det_in};
        nbits++;
      end
      if (done) begin
        done_n++;
        done_at = cyc;
        chk({tag, "_hit_done"}, hit_count, exp_hits);
      end
      @(posedge clock); #1;
    end
    force_hit = 1'b0;
    start = 1'b0;
    chk({tag, "_done_n"}, done_n, 1);
    chk({tag, "_done_at"}, done_at, exp_done);
    chk({tag, "_clr_n"}, clr_n, c ? 0 : 1);
    if (!c) chk({tag, "_clr_at"}, clr_at, 1);
    chk({tag, "_nbits"}, nbits, W);
    chk({tag, "_bits"}, seen, d);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_hold"}, hit_count, exp_hits);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] msk;
    int p;
    int done_n;
    checks = 0;
    errors = 0;
    force_hit = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    cont = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hit", hit_count, '0);
    chk("rst_clr", det_clear, 1'b0);
    chk("rst_en", det_en, 1'b0);
    chk("rst_din", det_in, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;

    scan(16'hB000, 1'b0, 1'b0, 1'b0, "basic");
    scan(16'hB6C0, 1'b0, 1'b0, 1'b0, "overlap");
    scan(16'h000B, 1'b0, 1'b0, 1'b0, "pairA1");
    scan(16'h0000, 1'b1, 1'b0, 1'b0, "pairA2");
    scan(16'h000B, 1'b0, 1'b0, 1'b0, "pairB1");
    scan(16'h0000, 1'b0, 1'b0, 1'b0, "pairB2");
    scan(16'hB000, 1'b0, 1'b1, 1'b0, "stale");
    scan(16'hB6C0, 1'b0, 1'b0, 1'b1, "glitch");
    scan(16'h2D6B, 1'b1, 1'b0, 1'b1, "glitch_c");

    start = 1'b1; data_in = 16'hB6C0; cont = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_q.delete();
    chk("mid_busy", busy, 1'b0);
    chk("mid_en", det_en, 1'b0);
    chk("mid_din", det_in, 1'b0);
    chk("mid_hit", hit_count, '0);
    chk("mid_done", done, 1'b0);
    chk("mid_clr", det_clear, 1'b0);
    done_n = 0;
    for (int i = 0; i < W + 8; i++) begin
      if (done || busy) done_n++;
      @(posedge clock); #1;
    end
    chk("mid_quiet", done_n, 0);
    scan(16'hB6C0, 1'b0, 1'b0, 1'b0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      d = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, W - 5);
        msk = W'(5'h1f) << p;
        d = (d & ~msk) | (W'(SCAN_PATTERN) << p);
      end
      scan(d, n == 0 ? 1'b0 : 1'($urandom), 1'b0,
           1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
